// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_io_responder
//  Description : Responder side of the CPU byte-wide memory bus. Serves a
//                RAM region (cpu_addr[17:16] != 2'b11) and a memory-mapped
//                I/O page (cpu_addr[17:16] == 2'b11) providing buffered byte
//                input/output FIFOs, a free-running 32-bit cycle counter with
//                a snapshot register, a sticky program-stop flag and the
//                cpu_rdy flow-control signal.
//  Ports       : clk_in, rst_in           clock, synchronous active-high reset
//                cpu_addr/cpu_dout/cpu_wr CPU request (address, write byte, strobe)
//                cpu_din                  registered read byte (1-cycle latency)
//                cpu_rdy                  0 = CPU must freeze (output FIFO full)
//                in_valid/in_data/in_ready   input byte stream into input FIFO
//                out_valid/out_data/out_ready output byte stream from output FIFO
//                program_stop             sticky, set by a write to offset 4
//                out_overflow             sticky, set when an I/O write is dropped
//  Revision    : 1.0  initial release
// ============================================================================
module mem_io_responder #(
    parameter int RAM_AW    = 17,
    parameter int OUT_DEPTH = 16,
    parameter int IN_DEPTH  = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        program_stop,
    output logic        out_overflow
);

    localparam int c_OUT_PW = $clog2(OUT_DEPTH);
    localparam int c_IN_PW  = $clog2(IN_DEPTH);
    localparam logic [c_OUT_PW:0] c_OUT_FULL = (c_OUT_PW+1)'(OUT_DEPTH);
    localparam logic [c_IN_PW:0]  c_IN_FULL  = (c_IN_PW+1)'(IN_DEPTH);

    // ------------------------------------------------------------------
    // Storage (never reset)
    // ------------------------------------------------------------------
    logic [7:0] r_ram     [2**RAM_AW];
    logic [7:0] r_out_mem [OUT_DEPTH];
    logic [7:0] r_in_mem  [IN_DEPTH];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]          r_din;
    logic                r_rdy;
    logic [31:0]         r_cycle;
    logic [31:0]         r_snap;
    logic                r_stop;
    logic                r_ovf;
    logic                r_prev_rd0;
    logic [c_OUT_PW-1:0] r_out_wp;
    logic [c_OUT_PW-1:0] r_out_rp;
    logic [c_OUT_PW:0]   r_out_count;
    logic [c_IN_PW-1:0]  r_in_wp;
    logic [c_IN_PW-1:0]  r_in_rp;
    logic [c_IN_PW:0]    r_in_count;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       w_is_io;
    logic [2:0] w_off;
    logic       w_io_rd0;
    logic       w_in_pop;
    logic       w_in_push;
    logic       w_out_push;
    logic [7:0] w_out_push_data;
    logic       w_out_pop;
    logic       w_out_full;
    logic       w_out_wr;
    logic       w_unused_addr;

    assign w_is_io  = (cpu_addr[17:16] == 2'b11);
    assign w_off    = cpu_addr[2:0];
    assign w_io_rd0 = w_is_io && !cpu_wr && (w_off == 3'd0);

    // Only the first cycle of an offset-0 read pops, so a CPU that holds the
    // address while frozen or stalled consumes exactly one byte.
    assign w_in_pop  = w_io_rd0 && !r_prev_rd0 && (r_in_count != '0);
    assign w_in_push = in_valid && in_ready;

    assign w_out_push      = w_is_io && cpu_wr &&
                             (((w_off == 3'd0) && (cpu_dout != 8'h00)) || (w_off == 3'd4));
    assign w_out_push_data = (w_off == 3'd4) ? 8'h00 : cpu_dout;
    assign w_out_pop       = (r_out_count != '0) && out_ready;
    assign w_out_full      = (r_out_count == c_OUT_FULL);
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign w_out_wr        = w_out_push && (!w_out_full || w_out_pop);

    // Address bits above the I/O page select are don't-care.
    assign w_unused_addr = ^cpu_addr[31:18];

    // ------------------------------------------------------------------
    // Memories
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (cpu_wr && !w_is_io) begin
            r_ram[cpu_addr[RAM_AW-1:0]] <= cpu_dout;
        end
        if (w_out_wr) begin
            r_out_mem[r_out_wp] <= w_out_push_data;
        end
        if (w_in_push) begin
            r_in_mem[r_in_wp] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Control / read path
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_din       <= 8'h00;
            r_rdy       <= 1'b1;
            r_cycle     <= 32'h0;
            r_snap      <= 32'h0;
            r_stop      <= 1'b0;
            r_ovf       <= 1'b0;
            r_prev_rd0  <= 1'b0;
            r_out_wp    <= '0;
            r_out_rp    <= '0;
            r_out_count <= '0;
            r_in_wp     <= '0;
            r_in_rp     <= '0;
            r_in_count  <= '0;
        end else begin
            r_cycle    <= r_cycle + 32'd1;
            r_prev_rd0 <= w_io_rd0;

            // Read data; writes leave cpu_din untouched.
            if (!cpu_wr) begin
                if (!w_is_io) begin
                    r_din <= r_ram[cpu_addr[RAM_AW-1:0]];
                end else begin
                    case (w_off)
                        3'd0: begin
                            // Continuation cycles of a held read keep the byte
                            // already returned instead of exposing the next one.
                            if (!r_prev_rd0) begin
                                r_din <= (r_in_count != '0) ? r_in_mem[r_in_rp] : 8'h00;
                            end
                        end
                        3'd4: begin
                            r_din  <= r_cycle[7:0];
                            r_snap <= r_cycle;
                        end
                        3'd5:    r_din <= r_snap[15:8];
                        3'd6:    r_din <= r_snap[23:16];
                        3'd7:    r_din <= r_snap[31:24];
                        default: r_din <= 8'h00;
                    endcase
                end
            end

            if (w_is_io && cpu_wr && (w_off == 3'd4)) begin
                r_stop <= 1'b1;
            end
            if (w_out_push && !w_out_wr) begin
                r_ovf <= 1'b1;
            end

            // Output FIFO
            if (w_out_wr) begin
                r_out_wp <= r_out_wp + 1'b1;
            end
            if (w_out_pop) begin
                r_out_rp <= r_out_rp + 1'b1;
            end
            case ({w_out_wr, w_out_pop})
                2'b10:   r_out_count <= r_out_count + 1'b1;
                2'b01:   r_out_count <= r_out_count - 1'b1;
                default: r_out_count <= r_out_count;
            endcase

            // Flow control lags the FIFO count by one cycle.
            r_rdy <= !w_out_full;

            // Input FIFO
            if (w_in_push) begin
                r_in_wp <= r_in_wp + 1'b1;
            end
            if (w_in_pop) begin
                r_in_rp <= r_in_rp + 1'b1;
            end
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_count <= r_in_count + 1'b1;
                2'b01:   r_in_count <= r_in_count - 1'b1;
                default: r_in_count <= r_in_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cpu_din      = r_din;
    assign cpu_rdy      = r_rdy;
    assign in_ready     = (r_in_count != c_IN_FULL);
    assign out_valid    = (r_out_count != '0);
    assign out_data     = (r_out_count != '0) ? r_out_mem[r_out_rp] : 8'h00;
    assign program_stop = r_stop;
    assign out_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_io_responder
//  Description : Directed self-checking bench for mem_io_responder. Inputs
//                are driven just after the falling edge and outputs sampled
//                at the following falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_io_responder;

    localparam int OUT_DEPTH = 16;
    localparam int IN_DEPTH  = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        program_stop;
    logic        out_overflow;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] r_ref_cycle;
    logic [31:0] w_exp_cnt;

    mem_io_responder #(
        .RAM_AW    (17),
        .OUT_DEPTH (OUT_DEPTH),
        .IN_DEPTH  (IN_DEPTH)
    ) u_dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .cpu_addr     (cpu_addr),
        .cpu_dout     (cpu_dout),
        .cpu_wr       (cpu_wr),
        .cpu_din      (cpu_din),
        .cpu_rdy      (cpu_rdy),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .program_stop (program_stop),
        .out_overflow (out_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle counter: zero in reset, +1 every other edge.
    always @(posedge clk_in) begin
        if (rst_in) r_ref_cycle <= 32'h0;
        else        r_ref_cycle <= r_ref_cycle + 32'd1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic idle();
        cpu_wr   = 1'b0;
        cpu_addr = 32'h0;
        cpu_dout = 8'h00;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_dout = d;
        cpu_wr   = 1'b1;
        cyc();
        idle();
    endtask

    task automatic bus_read(input logic [31:0] a);
        cpu_addr = a;
        cpu_wr   = 1'b0;
        cyc();
        idle();
    endtask

    initial begin
        rst_in    = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        idle();
        @(negedge clk_in);
        cyc();
        cyc();

        // Reset values
        check("rst_cpu_din",  {24'h0, cpu_din}, 32'h00);
        check("rst_cpu_rdy",  {31'h0, cpu_rdy}, 32'h1);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", {24'h0, out_data}, 32'h00);
        check("rst_stop",     {31'h0, program_stop}, 32'h0);
        check("rst_ovf",      {31'h0, out_overflow}, 32'h0);
        rst_in = 1'b0;

        // 1. RAM write then read
        bus_write(32'h0000_0100, 8'hA5);
        bus_write(32'h0000_0101, 8'h5A);
        bus_read(32'h0000_0100);
        check("ram_rd_100", {24'h0, cpu_din}, 32'hA5);
        bus_read(32'h0000_0101);
        check("ram_rd_101", {24'h0, cpu_din}, 32'h5A);
        // A write leaves cpu_din as it was
        bus_write(32'h0000_0200, 8'h77);
        check("ram_wr_hold", {24'h0, cpu_din}, 32'h5A);

        // 2. Output byte stream, zero filtered, then program stop
        bus_write(32'h0003_0000, 8'h41);
        bus_write(32'h0003_0000, 8'h00);
        bus_write(32'h0003_0000, 8'h42);
        check("out_first", {24'h0, out_data}, 32'h41);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("out_second", {24'h0, out_data}, 32'h42);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("out_empty", {31'h0, out_valid}, 32'h0);
        check("stop_before", {31'h0, program_stop}, 32'h0);
        // Upper address bits are ignored by the I/O decode
        bus_write(32'hFFF3_FFFC, 8'h99);
        check("stop_valid", {31'h0, out_valid}, 32'h1);
        check("stop_data",  {24'h0, out_data}, 32'h00);
        check("stop_flag",  {31'h0, program_stop}, 32'h1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // 3. Fill output FIFO, overflow, flow control
        for (int i = 0; i < OUT_DEPTH; i++) begin
            bus_write(32'h0003_0000, 8'(i + 1));
        end
        cyc();
        cyc();
        check("full_rdy", {31'h0, cpu_rdy}, 32'h0);
        check("full_ovf_clear", {31'h0, out_overflow}, 32'h0);
        bus_write(32'h0003_0000, 8'hEE);
        check("ovf_set", {31'h0, out_overflow}, 32'h1);
        check("ovf_head", {24'h0, out_data}, 32'h01);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        cyc();
        check("rdy_back", {31'h0, cpu_rdy}, 32'h1);
        for (int i = 2; i <= OUT_DEPTH; i++) begin
            check($sformatf("drain_%0d", i), {24'h0, out_data}, 32'(i));
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
        end
        check("drain_empty", {31'h0, out_valid}, 32'h0);

        // 4. Input FIFO with a held read
        in_valid = 1'b1;
        in_data  = 8'h11;
        cyc();
        in_data  = 8'h22;
        cyc();
        in_valid = 1'b0;
        cpu_addr = 32'h0003_0000;
        cpu_wr   = 1'b0;
        cyc();
        check("in_hold_c1", {24'h0, cpu_din}, 32'h11);
        cyc();
        cyc();
        check("in_hold_c3", {24'h0, cpu_din}, 32'h11);
        idle();
        cyc();
        bus_read(32'h0003_0000);
        check("in_second", {24'h0, cpu_din}, 32'h22);
        cyc();
        bus_read(32'h0003_0000);
        check("in_empty", {24'h0, cpu_din}, 32'h00);
        bus_read(32'h0003_0002);
        check("io_off2", {24'h0, cpu_din}, 32'h00);

        // 5. Cycle counter snapshot
        repeat (1000) cyc();
        cpu_addr  = 32'h0003_0004;
        cpu_wr    = 1'b0;
        w_exp_cnt = r_ref_cycle;
        cyc();
        idle();
        check("cnt_b0", {24'h0, cpu_din}, {24'h0, w_exp_cnt[7:0]});
        bus_read(32'h0003_0005);
        check("cnt_b1", {24'h0, cpu_din}, {24'h0, w_exp_cnt[15:8]});
        bus_read(32'h0003_0006);
        check("cnt_b2", {24'h0, cpu_din}, {24'h0, w_exp_cnt[23:16]});
        bus_read(32'h0003_0007);
        check("cnt_b3", {24'h0, cpu_din}, {24'h0, w_exp_cnt[31:24]});

        // 6. Reset with both FIFOs non-empty and a read pending
        in_valid = 1'b1;
        in_data  = 8'h33;
        cyc();
        in_valid = 1'b0;
        bus_write(32'h0003_0000, 8'h55);
        check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        rst_in   = 1'b1;
        cpu_addr = 32'h0000_0100;
        cpu_wr   = 1'b0;
        cyc();
        rst_in = 1'b0;
        idle();
        check("mid_rst_din",   {24'h0, cpu_din}, 32'h00);
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_data",  {24'h0, out_data}, 32'h00);
        check("mid_rst_stop",  {31'h0, program_stop}, 32'h0);
        check("mid_rst_ovf",   {31'h0, out_overflow}, 32'h0);
        check("mid_rst_rdy",   {31'h0, cpu_rdy}, 32'h1);
        check("mid_rst_inrdy", {31'h0, in_ready}, 32'h1);
        bus_read(32'h0003_0000);
        check("mid_rst_in_lost", {24'h0, cpu_din}, 32'h00);
        bus_read(32'h0000_0100);
        check("ram_kept", {24'h0, cpu_din}, 32'hA5);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
